// File: rtl/rule_conf_seq.sv
// Purpose : serializes one rule descriptor into an ordered burst of single-cycle rule-config writes.
// Latency : first write appears the cycle after acceptance; burst is 2*TYPE_NUM+KEY_FILED_NUM+3 back-to-back cycles.
// Backpr. : o_desc_ready is high only in IDLE; no backpressure from the config bus, i_abort ends a burst early.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_desc_* / o_desc_ready    descriptor valid/ready handshake and fields (captured on acceptance)
//   i_abort                    drops the current burst after the write in flight
//   o_rule_wren/wdata/addr     config write bus (addr[10:8] = selector, addr[7:0] = index)
//   o_busy, o_done             burst in progress, one-cycle pulse on the commit write
module rule_conf_seq #(
    parameter int RULE_NUM          = 16,
    parameter int TYPE_NUM          = 4,
    parameter int TYPE_WIDTH        = 16,
    parameter int TYPE_OFFSET_WIDTH = 6,
    parameter int KEY_FILED_NUM     = 8,
    parameter int KEY_OFFSET_WIDTH  = 6,
    parameter int HEAD_SHIFT_WIDTH  = 6,
    parameter int META_SHIFT_WIDTH  = 6
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_desc_valid,
    output logic                                          o_desc_ready,
    input  logic [5:0]                                    i_desc_ruleId,
    input  logic                                          i_desc_ruleValid,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]                i_desc_typeData,
    input  logic [TYPE_NUM*TYPE_WIDTH-1:0]                i_desc_typeMask,
    input  logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]         i_desc_typeOffset,
    input  logic [KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)-1:0] i_desc_keyOffset,
    input  logic [HEAD_SHIFT_WIDTH-1:0]                   i_desc_headShift,
    input  logic [META_SHIFT_WIDTH-1:0]                   i_desc_metaShift,
    input  logic                                          i_abort,
    output logic                                          o_rule_wren,
    output logic [31:0]                                   o_rule_wdata,
    output logic [31:0]                                   o_rule_addr,
    output logic                                          o_busy,
    output logic                                          o_done
);

    localparam int IDX_W = 8;
    localparam int KEW   = KEY_OFFSET_WIDTH + 1;

    // Parameter legality is checked at elaboration so a bad build never gets to silicon.
    if (RULE_NUM > 64 || TYPE_NUM > 16 || TYPE_WIDTH > 16 || TYPE_OFFSET_WIDTH > 32 ||
        KEY_FILED_NUM > 64 || KEY_OFFSET_WIDTH > 16) begin : g_param_check
        $error("rule_conf_seq: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_TYPE, S_TOFF, S_KEY, S_HEAD, S_META, S_RULE
    } state_t;

    state_t                                  state, nxt_state;
    logic [IDX_W-1:0]                        idx, nxt_idx;

    logic [5:0]                              rule_id_q;
    logic                                    rule_valid_q;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]          type_data_q, type_mask_q;
    logic [TYPE_NUM*TYPE_OFFSET_WIDTH-1:0]   type_off_q;
    logic [KEY_FILED_NUM*KEW-1:0]            key_off_q;
    logic [HEAD_SHIFT_WIDTH-1:0]             head_q;
    logic [META_SHIFT_WIDTH-1:0]             meta_q;

    logic                                    accept;
    logic [TYPE_NUM*TYPE_WIDTH-1:0]          td_src, tm_src;
    logic [TYPE_WIDTH-1:0]                   el_tdata, el_tmask;
    logic [TYPE_OFFSET_WIDTH-1:0]            el_toff;
    logic [KEW-1:0]                          el_key;
    logic [31:0]                             nxt_addr, nxt_wdata;

    assign accept = i_desc_valid & o_desc_ready;

    // The first TYPE write is formed in the acceptance cycle, before the capture
    // registers are loaded, so it must come straight from the descriptor inputs.
    assign td_src = (state == S_IDLE) ? i_desc_typeData : type_data_q;
    assign tm_src = (state == S_IDLE) ? i_desc_typeMask : type_mask_q;

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            S_IDLE: if (accept) begin nxt_state = S_TYPE; nxt_idx = '0; end
            S_TYPE: if (idx == IDX_W'(TYPE_NUM - 1)) begin nxt_state = S_TOFF; nxt_idx = '0; end
                    else nxt_idx = idx + 8'd1;
            S_TOFF: if (idx == IDX_W'(TYPE_NUM - 1)) begin nxt_state = S_KEY; nxt_idx = '0; end
                    else nxt_idx = idx + 8'd1;
            S_KEY:  if (idx == IDX_W'(KEY_FILED_NUM - 1)) begin nxt_state = S_HEAD; nxt_idx = '0; end
                    else nxt_idx = idx + 8'd1;
            S_HEAD: nxt_state = S_META;
            S_META: nxt_state = S_RULE;
            S_RULE: nxt_state = S_IDLE;
            default: begin nxt_state = S_IDLE; nxt_idx = '0; end
        endcase
        if (state != S_IDLE && i_abort) begin
            nxt_state = S_IDLE;
            nxt_idx   = '0;
        end
    end

    // Element selection as a constant-index mux keyed by the next index.
    always_comb begin
        el_tdata = '0;
        el_tmask = '0;
        el_toff  = '0;
        el_key   = '0;
        for (int i = 0; i < TYPE_NUM; i++) begin
            if (nxt_idx == IDX_W'(i)) begin
                el_tdata = td_src[i*TYPE_WIDTH +: TYPE_WIDTH];
                el_tmask = tm_src[i*TYPE_WIDTH +: TYPE_WIDTH];
                el_toff  = type_off_q[i*TYPE_OFFSET_WIDTH +: TYPE_OFFSET_WIDTH];
            end
        end
        for (int i = 0; i < KEY_FILED_NUM; i++) begin
            if (nxt_idx == IDX_W'(i)) el_key = key_off_q[i*KEW +: KEW];
        end
    end

    always_comb begin
        nxt_addr  = '0;
        nxt_wdata = '0;
        case (nxt_state)
            S_TYPE: begin
                nxt_addr                     = {21'd0, 3'd1, nxt_idx};
                nxt_wdata[16 +: TYPE_WIDTH]  = el_tdata;
                nxt_wdata[0 +: TYPE_WIDTH]   = el_tmask;
            end
            S_TOFF: begin
                nxt_addr                          = {21'd0, 3'd2, nxt_idx};
                nxt_wdata[0 +: TYPE_OFFSET_WIDTH] = el_toff;
            end
            S_KEY: begin
                nxt_addr                         = {21'd0, 3'd3, nxt_idx};
                nxt_wdata[16]                    = el_key[KEY_OFFSET_WIDTH];
                nxt_wdata[0 +: KEY_OFFSET_WIDTH] = el_key[KEY_OFFSET_WIDTH-1:0];
            end
            S_HEAD: begin
                nxt_addr                         = {21'd0, 3'd4, 8'd0};
                nxt_wdata[0 +: HEAD_SHIFT_WIDTH] = head_q;
            end
            S_META: begin
                nxt_addr                         = {21'd0, 3'd5, 8'd0};
                nxt_wdata[0 +: META_SHIFT_WIDTH] = meta_q;
            end
            S_RULE: begin
                // Rule id is passed through unchecked; the decoder owns range checking.
                nxt_addr     = {21'd0, 3'd0, 2'd0, rule_id_q};
                nxt_wdata[0] = rule_valid_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            o_desc_ready <= 1'b1;
            o_rule_wren  <= 1'b0;
            o_rule_addr  <= '0;
            o_rule_wdata <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            rule_id_q    <= '0;
            rule_valid_q <= 1'b0;
            type_data_q  <= '0;
            type_mask_q  <= '0;
            type_off_q   <= '0;
            key_off_q    <= '0;
            head_q       <= '0;
            meta_q       <= '0;
        end else begin
            state        <= nxt_state;
            idx          <= nxt_idx;
            o_desc_ready <= (nxt_state == S_IDLE);
            o_rule_wren  <= (nxt_state != S_IDLE);
            o_rule_addr  <= nxt_addr;
            o_rule_wdata <= nxt_wdata;
            o_busy       <= (nxt_state != S_IDLE);
            o_done       <= (nxt_state == S_RULE);
            if (accept) begin
                rule_id_q    <= i_desc_ruleId;
                rule_valid_q <= i_desc_ruleValid;
                type_data_q  <= i_desc_typeData;
                type_mask_q  <= i_desc_typeMask;
                type_off_q   <= i_desc_typeOffset;
                key_off_q    <= i_desc_keyOffset;
                head_q       <= i_desc_headShift;
                meta_q       <= i_desc_metaShift;
            end
        end
    end

endmodule

// File: tb/tb_rule_conf_seq.sv
// Purpose : self-checking bench for rule_conf_seq with a write-list reference model and a loopback decoder model.
// Latency : expects the first write one cycle after acceptance and 19 back-to-back writes at defaults.
// Backpr. : drives descriptors through valid/ready; exercises abort, reset mid-burst and back-to-back acceptance.
module tb_rule_conf_seq;

    localparam int TN  = 4;
    localparam int TW  = 16;
    localparam int TOW = 6;
    localparam int KN  = 8;
    localparam int KOW = 6;
    localparam int HSW = 6;
    localparam int MSW = 6;
    localparam int NW  = 2*TN + KN + 3;

    typedef struct {
        logic [5:0]            rid;
        logic                  rv;
        logic [TN*TW-1:0]      td;
        logic [TN*TW-1:0]      tm;
        logic [TN*TOW-1:0]     toff;
        logic [KN*(KOW+1)-1:0] koff;
        logic [HSW-1:0]        hs;
        logic [MSW-1:0]        ms;
    } desc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  valid, ready, abort;
    logic [5:0]            rid;
    logic                  rv;
    logic [TN*TW-1:0]      td, tm;
    logic [TN*TOW-1:0]     toff;
    logic [KN*(KOW+1)-1:0] koff;
    logic [HSW-1:0]        hs;
    logic [MSW-1:0]        ms;
    logic                  wren, busy, done;
    logic [31:0]           wdata, addr;

    rule_conf_seq dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_desc_valid     (valid),
        .o_desc_ready     (ready),
        .i_desc_ruleId    (rid),
        .i_desc_ruleValid (rv),
        .i_desc_typeData  (td),
        .i_desc_typeMask  (tm),
        .i_desc_typeOffset(toff),
        .i_desc_keyOffset (koff),
        .i_desc_headShift (hs),
        .i_desc_metaShift (ms),
        .i_abort          (abort),
        .o_rule_wren      (wren),
        .o_rule_wdata     (wdata),
        .o_rule_addr      (addr),
        .o_busy           (busy),
        .o_done           (done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Acceptance timestamps, taken from pre-edge values at each rising edge.
    int cyc = 0;
    int acc_cyc[$];
    always @(posedge clk) begin
        if (valid && ready) acc_cyc.push_back(cyc);
        cyc++;
    end

    // Loopback consumer: behaves like the parser's rule-configuration decoder.
    logic [TW-1:0]  dec_td[TN];
    logic [TW-1:0]  dec_tm[TN];
    logic [TOW-1:0] dec_toff[TN];
    logic           dec_kv[KN];
    logic [KOW-1:0] dec_ko[KN];
    logic [HSW-1:0] dec_hs;
    logic [MSW-1:0] dec_ms;
    logic           dec_rv[64];
    logic [63:0]    dec_onehot = '0;

    always @(posedge clk) begin
        int ix;
        ix = int'(addr[7:0]);
        dec_onehot <= '0;
        if (wren) begin
            case (addr[10:8])
                3'd1: if (ix < TN) begin dec_td[ix] <= wdata[16 +: TW]; dec_tm[ix] <= wdata[0 +: TW]; end
                3'd2: if (ix < TN) dec_toff[ix] <= wdata[0 +: TOW];
                3'd3: if (ix < KN) begin dec_kv[ix] <= wdata[16]; dec_ko[ix] <= wdata[0 +: KOW]; end
                3'd4: dec_hs <= wdata[HSW-1:0];
                3'd5: dec_ms <= wdata[MSW-1:0];
                3'd0: begin dec_rv[addr[5:0]] <= wdata[0]; dec_onehot <= 64'd1 << addr[5:0]; end
                default: ;
            endcase
        end
    end

    // Reference write list derived directly from the descriptor.
    logic [31:0] ea[$];
    logic [31:0] ew[$];
    logic [31:0] oa[NW];
    logic [31:0] ow[NW];
    logic        od[NW];

    task automatic build(input desc_t d);
        logic [KOW:0] e;
        ea.delete();
        ew.delete();
        for (int i = 0; i < TN; i++) begin
            ea.push_back(32'h100 + 32'(i));
            ew.push_back({d.td[i*TW +: TW], d.tm[i*TW +: TW]});
        end
        for (int i = 0; i < TN; i++) begin
            ea.push_back(32'h200 + 32'(i));
            ew.push_back(32'(d.toff[i*TOW +: TOW]));
        end
        for (int i = 0; i < KN; i++) begin
            e = d.koff[i*(KOW+1) +: KOW+1];
            ea.push_back(32'h300 + 32'(i));
            ew.push_back((32'(e[KOW]) << 16) | 32'(e[KOW-1:0]));
        end
        ea.push_back(32'h400); ew.push_back(32'(d.hs));
        ea.push_back(32'h500); ew.push_back(32'(d.ms));
        ea.push_back(32'(d.rid)); ew.push_back(32'(d.rv));
    endtask

    task automatic apply(input desc_t d);
        rid = d.rid; rv = d.rv; td = d.td; tm = d.tm;
        toff = d.toff; koff = d.koff; hs = d.hs; ms = d.ms;
    endtask

    task automatic rand_desc(output desc_t d);
        d.rid  = 6'($urandom_range(0, 63));
        d.rv   = 1'($urandom());
        d.td   = {$urandom(), $urandom()};
        d.tm   = {$urandom(), $urandom()};
        d.toff = 24'($urandom());
        d.koff = 56'({$urandom(), $urandom()});
        d.hs   = 6'($urandom());
        d.ms   = 6'($urandom());
    endtask

    // Presents a descriptor and returns at the negedge after the accepting edge.
    task automatic send(input desc_t d);
        int t;
        @(negedge clk);
        apply(d);
        valid = 1'b1;
        t = 0;
        while (!ready && t < 50) begin @(negedge clk); t++; end
        check("accept_ready", 64'(ready), 64'(1));
        @(negedge clk);
    endtask

    // Checks n consecutive writes starting at the current negedge; ends on the last one.
    task automatic check_writes(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            oa[k] = addr; ow[k] = wdata; od[k] = done;
            check($sformatf("%s_w%0d_wren",  tag, k), 64'(wren),  64'(1));
            check($sformatf("%s_w%0d_addr",  tag, k), 64'(addr),  64'(ea[k]));
            check($sformatf("%s_w%0d_wdata", tag, k), 64'(wdata), 64'(ew[k]));
            check($sformatf("%s_w%0d_done",  tag, k), 64'(done),  64'(k == NW-1));
            check($sformatf("%s_w%0d_busy",  tag, k), 64'(busy),  64'(1));
            check($sformatf("%s_w%0d_ready", tag, k), 64'(ready), 64'(0));
        end
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_idle_wren"},  64'(wren),  64'(0));
        check({tag, "_idle_done"},  64'(done),  64'(0));
        check({tag, "_idle_busy"},  64'(busy),  64'(0));
        check({tag, "_idle_ready"}, 64'(ready), 64'(1));
        check({tag, "_idle_addr"},  64'(addr),  64'(0));
        check({tag, "_idle_wdata"}, 64'(wdata), 64'(0));
    endtask

    task automatic dec_checks(input string tag, input desc_t d);
        logic [TN*TW-1:0]      gtd, gtm;
        logic [TN*TOW-1:0]     gtoff;
        logic [KN*(KOW+1)-1:0] gkoff;
        for (int i = 0; i < TN; i++) begin
            gtd[i*TW +: TW]    = dec_td[i];
            gtm[i*TW +: TW]    = dec_tm[i];
            gtoff[i*TOW +: TOW] = dec_toff[i];
        end
        for (int i = 0; i < KN; i++) gkoff[i*(KOW+1) +: KOW+1] = {dec_kv[i], dec_ko[i]};
        check({tag, "_dec_td"},     64'(gtd),   64'(d.td));
        check({tag, "_dec_tm"},     64'(gtm),   64'(d.tm));
        check({tag, "_dec_toff"},   64'(gtoff), 64'(d.toff));
        check({tag, "_dec_koff"},   64'(gkoff), 64'(d.koff));
        check({tag, "_dec_hs"},     64'(dec_hs), 64'(d.hs));
        check({tag, "_dec_ms"},     64'(dec_ms), 64'(d.ms));
        check({tag, "_dec_rv"},     64'(dec_rv[d.rid]), 64'(d.rv));
        check({tag, "_dec_onehot"}, dec_onehot, 64'd1 << d.rid);
    endtask

    task automatic full_burst(input string tag, input desc_t d, input bit dead, input desc_t dd);
        build(d);
        send(d);
        valid = 1'b0;
        if (dead) apply(dd);
        check_writes(tag, NW);
        @(negedge clk);
        idle_checks(tag);
        dec_checks(tag, d);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        desc_t d, d2, dead_d, zero_d;
        int n0, cnt_w, cnt_d;

        zero_d = '{default: '0};
        dead_d.rid = 6'h2D; dead_d.rv = 1'b0;
        dead_d.td = {4{16'hDEAD}}; dead_d.tm = {4{16'hDEAD}};
        dead_d.toff = 24'hDEADDE; dead_d.koff = 56'hDEADDEADDEADDE;
        dead_d.hs = 6'h2D; dead_d.ms = 6'h2D;

        rst_n = 1'b1; valid = 1'b0; abort = 1'b0;
        apply(zero_d);
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_wren",  64'(wren),  64'(0));
        check("rst_addr",  64'(addr),  64'(0));
        check("rst_wdata", 64'(wdata), 64'(0));
        check("rst_busy",  64'(busy),  64'(0));
        check("rst_done",  64'(done),  64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed descriptor with known expected encodings.
        d = zero_d;
        d.rid = 6'd5; d.rv = 1'b1; d.td = 64'h0800; d.tm = 64'hFFFF;
        d.koff = 56'(7'h4C) << 14; d.hs = 6'd14; d.ms = 6'd3;
        full_burst("d1", d, 1'b0, zero_d);
        check("d1_w0_addr",  64'(oa[0]),  64'h100);
        check("d1_w0_wdata", 64'(ow[0]),  64'h0800FFFF);
        check("d1_w10_addr", 64'(oa[10]), 64'h302);
        check("d1_w10_wdata",64'(ow[10]), 64'h0001000C);
        check("d1_w18_addr", 64'(oa[18]), 64'h005);
        check("d1_w18_wdata",64'(ow[18]), 64'h1);
        check("d1_w18_done", 64'(od[18]), 64'h1);

        // Inputs scrambled right after acceptance must not leak into the burst.
        rand_desc(d);
        full_burst("dead", d, 1'b1, dead_d);

        // Back-to-back with valid held high.
        rand_desc(d);
        rand_desc(d2);
        n0 = acc_cyc.size();
        build(d);
        send(d);
        check_writes("bbA", NW);
        @(negedge clk);
        check("bb_gap_wren",  64'(wren),  64'(0));
        check("bb_gap_busy",  64'(busy),  64'(0));
        check("bb_gap_ready", 64'(ready), 64'(1));
        apply(d2);
        build(d2);
        @(negedge clk);
        valid = 1'b0;
        check_writes("bbB", NW);
        @(negedge clk);
        idle_checks("bbB");
        dec_checks("bbB", d2);
        check("bb_acc_count", 64'(acc_cyc.size() - n0), 64'(2));
        if (acc_cyc.size() - n0 == 2)
            check("bb_acc_spacing", 64'(acc_cyc[n0+1] - acc_cyc[n0]), 64'(NW + 1));

        // Abort during KEY index 3.
        rand_desc(d);
        build(d);
        send(d);
        valid = 1'b0;
        check_writes("ab", 2*TN + 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        idle_checks("ab");
        cnt_w = 0; cnt_d = 0;
        repeat (25) begin
            @(negedge clk);
            if (wren) cnt_w++;
            if (done) cnt_d++;
        end
        check("ab_quiet_wren", 64'(cnt_w), 64'(0));
        check("ab_quiet_done", 64'(cnt_d), 64'(0));

        // Abort coinciding with acceptance: acceptance wins, full burst follows.
        rand_desc(d);
        build(d);
        @(negedge clk);
        apply(d);
        valid = 1'b1;
        abort = 1'b1;
        check("aa_ready", 64'(ready), 64'(1));
        @(negedge clk);
        abort = 1'b0;
        valid = 1'b0;
        check_writes("aa", NW);
        @(negedge clk);
        idle_checks("aa");
        dec_checks("aa", d);

        // Asynchronous reset mid-TOFF.
        rand_desc(d);
        build(d);
        send(d);
        valid = 1'b0;
        check_writes("rs", TN + 2);
        #2 rst_n = 1'b0;
        #1;
        check("rs_wren",  64'(wren),  64'(0));
        check("rs_busy",  64'(busy),  64'(0));
        check("rs_ready", 64'(ready), 64'(1));
        check("rs_done",  64'(done),  64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_w = 0;
        repeat (30) begin
            @(negedge clk);
            if (wren) cnt_w++;
        end
        check("rs_quiet_wren", 64'(cnt_w), 64'(0));
        rand_desc(d);
        full_burst("rs2", d, 1'b0, zero_d);

        // Randomized loopback against the decoder model.
        for (int it = 0; it < 200; it++) begin
            rand_desc(d);
            full_burst("lb", d, 1'b0, zero_d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rule_conf_seq.md
Name: rule_conf_seq

Overview:
- Initiator side of the 32-bit rule-configuration write bus (wren/wdata/addr) consumed by the parser's rule-configuration decoder.
- Accepts one complete rule descriptor through a valid/ready handshake and serializes it into an ordered burst of single-cycle config writes.
- Order: type data/mask, type offsets, key offsets, head shift, meta shift, and finally the rule-commit write that pulses the rule write-enable.
- Sits between the control-plane loader (CPU/UART/PCIe shim) and the parser's rule configuration port.

Parameters:
- RULE_NUM, 16: number of rule slots; must be ≤64.
- TYPE_NUM, 4: type fields per rule; must be ≤16.
- TYPE_WIDTH, 16: type data/mask width; must be ≤16.
- TYPE_OFFSET_WIDTH, 6: type offset width; must be ≤32.
- KEY_FILED_NUM, 8: key fields per rule; must be ≤64.
- KEY_OFFSET_WIDTH, 6: key offset width; must be ≤16.
- HEAD_SHIFT_WIDTH, 6: head shift width.
- META_SHIFT_WIDTH, 6: meta shift width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_desc_valid  in  1  descriptor valid
- o_desc_ready  out  1  descriptor ready; high only in IDLE
- i_desc_ruleId  in  6  target rule slot
- i_desc_ruleValid  in  1  valid bit written with the commit
- i_desc_typeData  in  TYPE_NUM*TYPE_WIDTH  element i at [i*TYPE_WIDTH +: TYPE_WIDTH]
- i_desc_typeMask  in  TYPE_NUM*TYPE_WIDTH  same packing
- i_desc_typeOffset  in  TYPE_NUM*TYPE_OFFSET_WIDTH  same packing
- i_desc_keyOffset  in  KEY_FILED_NUM*(KEY_OFFSET_WIDTH+1)  per element: top bit = key valid, low bits = offset
- i_desc_headShift  in  HEAD_SHIFT_WIDTH  head shift
- i_desc_metaShift  in  META_SHIFT_WIDTH  meta shift
- i_abort  in  1  synchronous abort of the current burst
- o_rule_wren  out  1  config write strobe
- o_rule_wdata  out  32  config write data
- o_rule_addr  out  32  config write address
- o_busy  out  1  burst in progress
- o_done  out  1  one-cycle pulse coincident with the commit write

Behaviour:
- Reset: i_rst_n is asynchronous, active-low; clock is i_clk. All outputs are 0 during reset except o_desc_ready = 1; FSM = IDLE; index counter = 0. Reset asserted mid-burst kills the burst; no further writes are issued after release.
- Handshake: the descriptor is accepted when i_desc_valid & o_desc_ready at a rising edge. All descriptor fields are captured into internal registers that cycle, so inputs may change afterwards. o_desc_ready deasserts the cycle after acceptance.
- FSM states: IDLE -> TYPE -> TOFF -> KEY -> HEAD -> META -> RULE -> IDLE.
  - TYPE, TOFF and KEY iterate an index 0..N-1: one write per cycle, index cleared on each state exit.
  - HEAD, META and RULE are one cycle each.
- Write encoding:
  - Every write cycle has o_rule_wren = 1.
  - addr[31:11] = 0, addr[10:8] = selector, addr[7:0] = index, zero-extended. Unused wdata bits are 0.
  - TYPE (sel 1): wdata[16 +: TYPE_WIDTH] = typeData[i], wdata[0 +: TYPE_WIDTH] = typeMask[i].
  - TOFF (sel 2): wdata[0 +: TYPE_OFFSET_WIDTH] = typeOffset[i].
  - KEY (sel 3): wdata[16] = key valid bit, wdata[0 +: KEY_OFFSET_WIDTH] = key offset.
  - HEAD (sel 4): wdata = headShift, zero-extended.
  - META (sel 5): wdata = metaShift, zero-extended.
  - RULE (sel 0): addr[7:0] = ruleId, wdata[0] = ruleValid, o_done = 1.
- Outputs are registered. Outside write cycles, o_rule_wren = 0 and addr/wdata = 0.
- Latency and timing:
  - Acceptance at edge E0 produces the first write in the cycle after E0.
  - Burst length = 2*TYPE_NUM + KEY_FILED_NUM + 3 cycles (19 at defaults), back-to-back with no gaps.
  - o_desc_ready returns high in the cycle after the RULE write, so the minimum descriptor-to-descriptor spacing is burst length + 1 cycles.
- o_busy = 1 from the first write cycle through the RULE cycle inclusive.
- Abort:
  - i_abort = 1 in a non-IDLE state returns the FSM to IDLE at the next edge. The write in the current cycle still completes; no RULE write and no o_done are produced.
  - i_abort in IDLE has no effect.
  - i_abort together with acceptance: acceptance wins.
- An out-of-range ruleId (≥ RULE_NUM) is still issued unchanged; range checking is the decoder's responsibility.

Test Plan:
- Single descriptor at defaults: ruleId 5, ruleValid 1, typeData[0] = 0x0800, typeMask[0] = 0xFFFF, keyOffset[2] = {1, 6'd12}, headShift 14, metaShift 3.
  - Exactly 19 consecutive writes.
  - Write 0: addr 0x100, wdata 0x0800FFFF.
  - Write 10: addr 0x302, wdata 0x0001000C.
  - Write 18: addr 0x005, wdata 0x1, with o_done = 1.
- Back-to-back descriptors with i_desc_valid held high: second acceptance occurs exactly 20 cycles after the first; no overlap of writes; o_busy drops for exactly 1 cycle.
- Descriptor inputs changed to 0xDEAD patterns one cycle after acceptance -> emitted writes still carry the captured values.
- i_abort pulsed during KEY index 3 -> KEY index 3 write issued, then o_rule_wren = 0, no RULE write, no o_done, o_desc_ready = 1 in the next cycle.
- i_rst_n asserted asynchronously mid-TOFF -> o_rule_wren drops immediately. After release, no writes occur until a new descriptor arrives, which then produces a full 19-write burst.
- Loopback: sequencer output drives the rule-configuration decoder with random descriptors (200 iterations) -> decoder registers match the descriptor fields after each o_done; rule write-enable one-hot at ruleId.
